// File: rtl/polar_pkg.sv
// rtl/polar_pkg.sv - shared LLR types, bank states and saturation helper
package polar_pkg;

  localparam int WIDTH    = 8;
  localparam int IN_WIDTH = 12;

  typedef logic signed [WIDTH-1:0] llr_t;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } bank_state_e;

  typedef struct packed {
    llr_t q;
    logic clip;
  } sat_t;

  // Arithmetic shift then clamp to the symmetric range so -2^(WIDTH-1) never appears
  function automatic sat_t sat_llr(input logic signed [IN_WIDTH-1:0] in, input int unsigned shift);
    logic signed [IN_WIDTH-1:0] s;
    logic signed [IN_WIDTH-1:0] pos;
    logic signed [IN_WIDTH-1:0] neg;
    sat_t r;
    s      = in >>> shift;
    pos    = IN_WIDTH'((1 << (WIDTH - 1)) - 1);
    neg    = -pos;
    r.clip = 1'b0;
    r.q    = s[WIDTH-1:0];
    if (s > pos) begin
      r.q    = pos[WIDTH-1:0];
      r.clip = 1'b1;
    end else if (s < neg) begin
      r.q    = neg[WIDTH-1:0];
      r.clip = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/polar_llr_quant.sv
// rtl/polar_llr_quant.sv - combinational shift and symmetric saturation of one LLR
module polar_llr_quant #(
  parameter int IN_WIDTH = 12,
  parameter int WIDTH    = 8,
  parameter int SHIFT    = 2
) (
  input  logic signed [IN_WIDTH-1:0] in_llr,
  output logic signed [WIDTH-1:0]    q,
  output logic                       clip
);

  localparam logic signed [IN_WIDTH-1:0] POS = IN_WIDTH'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [IN_WIDTH-1:0] NEG = -POS;

  logic signed [IN_WIDTH-1:0] shifted;

  // Floor-shift, then clip to +/-(2^(WIDTH-1)-1) and flag the clip
  always_comb begin
    shifted = in_llr >>> SHIFT;
    q       = shifted[WIDTH-1:0];
    clip    = 1'b0;
    if (shifted > POS) begin
      q    = POS[WIDTH-1:0];
      clip = 1'b1;
    end else if (shifted < NEG) begin
      q    = NEG[WIDTH-1:0];
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/polar_llr_framer.sv
// rtl/polar_llr_framer.sv - ping-pong framer from serial LLR stream to parallel frames
module polar_llr_framer #(
  parameter int N        = 8,
  parameter int WIDTH    = 8,
  parameter int IN_WIDTH = 12,
  parameter int SHIFT    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [IN_WIDTH-1:0] in_llr,
  input  logic                       in_last,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic signed [WIDTH-1:0]    frame_llr [N],
  output logic                       frame_err,
  output logic [15:0]                sat_cnt
);

  import polar_pkg::*;

  localparam int IW = $clog2(N);
  localparam int FW = IW + 1;

  logic signed [WIDTH-1:0] mem [2][N];
  bank_state_e             st [2];
  logic [FW-1:0]           fill [2];
  logic                    wr_bank;
  logic                    rd_bank;
  logic [IW-1:0]           wr_idx;

  logic signed [WIDTH-1:0] q;
  logic                    clip;
  logic                    xfer;
  logic                    at_end;
  logic                    close;
  logic                    consume;

  polar_llr_quant #(
    .IN_WIDTH(IN_WIDTH),
    .WIDTH   (WIDTH),
    .SHIFT   (SHIFT)
  ) u_quant (
    .in_llr(in_llr),
    .q     (q),
    .clip  (clip)
  );

  // Ready and valid depend only on bank state registers, never on frame_ready
  assign in_ready    = (st[wr_bank] != FULL);
  assign frame_valid = (st[rd_bank] == FULL);
  assign xfer        = in_valid && in_ready;
  assign at_end      = (wr_idx == IW'(N - 1));
  assign close       = xfer && (in_last || at_end);
  assign consume     = frame_valid && frame_ready;

  // Present the read bank, zeroing positions past the stored fill count
  always_comb begin
    for (int i = 0; i < N; i++) begin
      frame_llr[i] = (frame_valid && (FW'(i) < fill[rd_bank])) ? mem[rd_bank][i] : '0;
    end
  end

  // Bank state machines, pointers and sample storage; close and consume always hit different banks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        st[b]   <= EMPTY;
        fill[b] <= '0;
        for (int i = 0; i < N; i++) begin
          mem[b][i] <= '0;
        end
      end
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
    end else begin
      if (xfer) begin
        mem[wr_bank][wr_idx] <= q;
        if (close) begin
          st[wr_bank]   <= FULL;
          fill[wr_bank] <= {1'b0, wr_idx} + FW'(1);
          wr_bank       <= ~wr_bank;
          wr_idx        <= '0;
        end else begin
          st[wr_bank] <= FILLING;
          wr_idx      <= wr_idx + IW'(1);
        end
      end
      if (consume) begin
        st[rd_bank] <= EMPTY;
        rd_bank     <= ~rd_bank;
      end
    end
  end

  // Flag a frame closed by an early last or by a full bank with no last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= xfer && (in_last != at_end);
    end
  end

  // Count clipped samples, holding at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (xfer && clip && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_polar_llr_framer.sv
// tb/tb_polar_llr_framer.sv - scoreboard bench for polar_llr_framer
module tb_polar_llr_framer;

  localparam int N        = 8;
  localparam int WIDTH    = 8;
  localparam int IN_WIDTH = 12;
  localparam int SHIFT    = 2;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic signed [IN_WIDTH-1:0] in_llr = '0;
  logic                       in_last = 1'b0;
  logic                       frame_valid;
  logic                       frame_ready = 1'b0;
  logic signed [WIDTH-1:0]    frame_llr [N];
  logic                       frame_err;
  logic [15:0]                sat_cnt;

  always #5 clk = ~clk;

  polar_llr_framer #(
    .N       (N),
    .WIDTH   (WIDTH),
    .IN_WIDTH(IN_WIDTH),
    .SHIFT   (SHIFT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_llr     (in_llr),
    .in_last    (in_last),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_llr  (frame_llr),
    .frame_err  (frame_err),
    .sat_cnt    (sat_cnt)
  );

  typedef struct packed {
    logic signed [IN_WIDTH-1:0] llr;
    logic                       last;
  } stim_t;

  stim_t                sq[$];
  logic [N*WIDTH-1:0]   sb[$];
  int                   total = 0;
  int                   bad = 0;
  bit                   mon_en = 1'b0;
  bit                   xfer = 1'b0;
  bit                   exp_err = 1'b0;
  int                   exp_sat = 0;
  int                   cf[N];
  int                   cidx = 0;
  int                   p_valid = 100;
  int                   p_ready = 100;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference quantiser: real-valued floor division, then symmetric clamp
  function automatic int model_q(input int v, output bit clipped);
    int lim;
    int q;
    lim     = 2 ** (WIDTH - 1) - 1;
    q       = int'($floor(real'(v) / real'(2 ** SHIFT)));
    clipped = (q > lim) || (q < -lim);
    if (q > lim) q = lim;
    if (q < -lim) q = -lim;
    return q;
  endfunction

  task automatic accept(input stim_t s);
    bit                 c;
    int                 q;
    logic [N*WIDTH-1:0] fr;
    q = model_q(int'(s.llr), c);
    if (c && exp_sat < 65535) exp_sat++;
    cf[cidx] = q;
    cidx++;
    if (s.last || cidx == N) begin
      fr = '0;
      for (int i = 0; i < N; i++) begin
        if (i < cidx) fr[i*WIDTH +: WIDTH] = WIDTH'(cf[i]);
      end
      sb.push_back(fr);
      exp_err = (s.last != (cidx == N));
      cidx = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    exp_err = 1'b0;
    if (xfer) accept(sq.pop_front());
    #2;
    frame_ready = ($urandom_range(99) < p_ready);
    in_valid    = (sq.size() > 0) && ($urandom_range(99) < p_valid);
    if (in_valid) begin
      in_llr  = sq[0].llr;
      in_last = sq[0].last;
    end else begin
      in_llr  = IN_WIDTH'($urandom);
      in_last = 1'b0;
    end
    xfer = in_valid && in_ready;
  endtask

  task automatic push(input int v, input bit last);
    stim_t s;
    s.llr  = IN_WIDTH'(v);
    s.last = last;
    sq.push_back(s);
  endtask

  task automatic push_rand(input int len, input bit with_last);
    for (int i = 0; i < len; i++) begin
      push(int'($urandom_range(4095)) - 2048, with_last && (i == len - 1));
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((sq.size() > 0 || sb.size() > 0 || xfer) && k < budget) begin
      cycle();
      k++;
    end
    check("drain_timeout", int'(k >= budget), 0);
  endtask

  // Monitor: compare DUT outputs against the scoreboard every cycle
  initial begin
    logic [N*WIDTH-1:0] fr;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("in_ready", int'(in_ready), int'(sb.size() < 2));
        check("frame_valid", int'(frame_valid), int'(sb.size() > 0));
        check("frame_err", int'(frame_err), int'(exp_err));
        check("sat_cnt", int'(sat_cnt), exp_sat);
        if (frame_valid && sb.size() > 0) begin
          fr = sb[0];
          for (int i = 0; i < N; i++) begin
            check($sformatf("frame_llr[%0d]", i), int'(frame_llr[i]),
                  int'($signed(fr[i*WIDTH +: WIDTH])));
          end
          if (frame_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nx;
    // reset state
    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_frame_valid", int'(frame_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_sat_cnt", int'(sat_cnt), 0);
    for (int i = 0; i < N; i++) check("rst_frame_llr", int'(frame_llr[i]), 0);
    @(posedge clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // directed vector, one clip on 2047
    p_valid = 100;
    p_ready = 100;
    push(0, 0); push(4, 0); push(-4, 0); push(8, 0);
    push(-8, 0); push(100, 0); push(-100, 0); push(2047, 1);
    drain(100);
    check("sat_after_vec", int'(sat_cnt), 1);

    // negative saturation and boundaries around +/-127
    push(-2048, 0); push(-509, 0); push(-508, 0); push(508, 0);
    push(511, 0); push(512, 0); push(-1, 0); push(-5, 1);
    drain(100);
    check("sat_after_bounds", int'(sat_cnt), 4);

    // backpressure: three frames with no consumer
    p_ready = 0;
    push_rand(8, 1); push_rand(8, 1); push_rand(8, 1);
    for (int c = 0; c < 40; c++) cycle();
    check("bp_left", sq.size(), 8);
    check("bp_in_ready", int'(in_ready), 0);
    p_ready = 100;
    cycle();
    p_ready = 0;
    for (int c = 0; c < 4; c++) cycle();
    p_ready = 100;
    drain(200);

    // early last, then missing last
    push_rand(5, 1);
    push_rand(8, 0);
    drain(100);

    // continuous stream: one sample per clock including close/consume overlap
    for (int f = 0; f < 4; f++) push_rand(8, 1);
    nx = 0;
    for (int c = 0; c < 32; c++) begin
      cycle();
      if (xfer) nx++;
    end
    check("throughput", nx, 32);
    drain(100);

    // randomised frames and handshakes
    p_valid = 70;
    p_ready = 60;
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(5) == 0) push_rand(8, 0);
      else push_rand(int'($urandom_range(N - 1)) + 1, 1);
    end
    drain(5000);

    // asynchronous reset with one full bank and a partial frame
    p_valid = 100;
    p_ready = 0;
    push_rand(8, 1);
    push_rand(8, 1);
    for (int c = 0; c < 11; c++) cycle();
    p_valid = 0;
    cycle();
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("arst_frame_valid", int'(frame_valid), 0);
    check("arst_in_ready", int'(in_ready), 1);
    check("arst_sat_cnt", int'(sat_cnt), 0);
    sq.delete();
    sb.delete();
    cidx        = 0;
    exp_sat     = 0;
    exp_err     = 1'b0;
    xfer        = 1'b0;
    in_valid    = 1'b0;
    frame_ready = 1'b0;
    @(posedge clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    p_valid = 100;
    p_ready = 100;
    push(0, 0); push(4, 0); push(-4, 0); push(8, 0);
    push(-8, 0); push(100, 0); push(-100, 0); push(2047, 1);
    drain(100);
    check("post_rst_sat", int'(sat_cnt), 1);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
